ifetch_unit: RTL

- Instruction-fetch stage directly downstream of the program counter register.
- Takes the current PC, issues requests to the instruction memory over a req/gnt/rvalid handshake, and pairs each response with its PC.
- Buffers fetched instructions in a small FIFO and presents them to decode over valid/ready.
- Supports a flush/redirect that discards queued and in-flight instructions when a taken branch or jump changes the PC.

---
 rtl/core_pkg.sv | 25 ++
 rtl/ifetch_fifo.sv | 69 ++++++
 rtl/ifetch_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the fetch front end: the fetch entry handed
// to decode and the PC/misalign tag that waits for its memory response.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            misalign;
  } fetch_entry_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            misalign;
  } pend_entry_t;

  localparam fetch_entry_t FETCH_RST = '{inst: NOP_INST, pc: '0, misalign: 1'b0};

  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO with push/pop/count and a single-cycle flush.
// Storage resets to RST_VAL so the head output is defined straight out of reset.
module ifetch_fifo #(
  parameter int           W       = 8,
  parameter int           DEPTH   = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [AW:0]             count_q, count_d;
  logic                    do_push, do_pop;

  always_comb begin
    full     = (count_q == FULL_CNT);
    empty    = (count_q == '0);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= {DEPTH{RST_VAL}};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: issues PCs to imem under a credit limit, tags responses
// with their PC, buffers them for decode and discards stale ones after a flush.
module ifetch_unit
  import core_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = core_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic            pc_valid,
  output logic            pc_ready,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_misalign,
  input  logic            inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);

  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] buf_count, pend_count;
  logic [CW:0]   credit_used;
  logic          issue, resp, drop_resp;
  logic          buf_push, buf_pop, buf_full, buf_empty;
  logic          pend_full, pend_empty;
  pend_entry_t   pend_din, pend_head;
  fetch_entry_t  buf_din, buf_head;

  // A decode pop this cycle frees a slot in time for the next response, so
  // counting it keeps a 1-cycle memory streaming at one instruction per cycle.
  always_comb begin
    buf_pop     = !buf_empty && inst_ready && !flush;
    credit_used = {1'b0, buf_count} + {1'b0, outst_q} - (CW+1)'(buf_pop);
    imem_req    = !rst && pc_valid && !flush && (credit_used < CREDIT_MAX);
    issue       = imem_req && imem_gnt;
    resp        = imem_rvalid && (outst_q != '0);
    drop_resp   = resp && (flush || (drop_q != '0));
    buf_push    = resp && !drop_resp;
  end

  always_comb begin
    outst_d = outst_q + CW'(issue) - CW'(resp);
    drop_d  = drop_q;
    if (flush) drop_d = outst_q - CW'(resp);
    else if (resp && (drop_q != '0)) drop_d = drop_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    pend_din          = '0;
    pend_din.pc       = pc_in;
    pend_din.misalign = (pc_in[1:0] != 2'b00);
    buf_din           = '0;
    buf_din.inst      = imem_rdata;
    buf_din.pc        = pend_head.pc;
    buf_din.misalign  = pend_head.misalign;
  end

  // Pending-PC entries are not flushed: they retire with their (dropped) responses.
  ifetch_fifo #(.W($bits(pend_entry_t)), .DEPTH(DEPTH), .RST_VAL('0)) u_pend (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (issue),
    .din   (pend_din),
    .pop   (resp),
    .dout  (pend_head),
    .count (pend_count),
    .full  (pend_full),
    .empty (pend_empty)
  );

  ifetch_fifo #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH), .RST_VAL(FETCH_RST)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (buf_push),
    .din   (buf_din),
    .pop   (buf_pop),
    .dout  (buf_head),
    .count (buf_count),
    .full  (buf_full),
    .empty (buf_empty)
  );

  assign pc_ready      = issue;
  assign imem_addr     = word_addr(pc_in);
  assign inst_valid    = !buf_empty;
  assign inst_out      = buf_head.inst;
  assign inst_pc       = buf_head.pc;
  assign inst_misalign = buf_head.misalign;

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_buf_overflow: assert (!(buf_push && buf_full && !buf_pop));
      a_credit: assert (({1'b0, buf_count} + {1'b0, outst_q}) <= CREDIT_MAX);
      a_pend_track: assert (pend_count == outst_q);
      a_pend_push: assert (!(issue && pend_full && !resp));
      a_pend_pop: assert (!(resp && pend_empty));
    end
  end

endmodule
